// File: rtl/best_neighbor_scan.sv
// Scans the neighbour table: picks the lowest-Q neighbour and lists every neighbour better than our own Q.
// Optional macro SKIP_SELF_EN: entries whose ID equals MY_NODE_ID are skipped entirely.
//
// state    | meaning
// IDLE     | wait for start_scan, latch own Q-value
// INIT     | reset best tracking, address first ID or go straight to count write
// RD_ID    | capture neighbour ID, address its Q-value
// RD_Q     | capture Q-value, address its hop count
// RD_HOP   | capture hop count
// EVAL     | update best, launch list write if better than own Q
// WR_LIST  | list write strobe active, advance to next entry
// WR_COUNT | write better-list length
// DONE     | results held until start_scan drops
module best_neighbor_scan (
    input  logic        clock,
    input  logic        nreset,
    input  logic        start_scan,
    input  logic [15:0] neighbor_count,
    input  logic [15:0] my_qvalue,
    input  logic [15:0] MY_NODE_ID,
    input  logic [15:0] data_in,
    output logic [15:0] address,
    output logic [15:0] data_out,
    output logic        wr_en,
    output logic [15:0] mybest,
    output logic [15:0] bestvalue,
    output logic [15:0] besthop,
    output logic [15:0] bestneighborID,
    output logic [15:0] better_count,
    output logic        done_scan,
    output logic [7:0]  cstate
);
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INIT     = 4'd1,
        S_RD_ID    = 4'd2,
        S_RD_Q     = 4'd3,
        S_RD_HOP   = 4'd4,
        S_EVAL     = 4'd5,
        S_WR_LIST  = 4'd6,
        S_WR_COUNT = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    localparam logic [15:0] ID_BASE    = 16'h0600;
    localparam logic [15:0] Q_BASE     = 16'h0620;
    localparam logic [15:0] HOP_BASE   = 16'h0640;
    localparam logic [15:0] LIST_BASE  = 16'h0668;
    localparam logic [15:0] COUNT_ADDR = 16'h068C;
    localparam logic [15:0] NONE_ID    = 16'd100;

    state_t      state;
    logic [4:0]  idx;
    logic [4:0]  k_cnt;
    logic [4:0]  n_lat;
    logic [15:0] cur_id;
    logic [15:0] cur_q;
    logic [15:0] cur_hop;
    logic [4:0]  n_clamped;
    logic [4:0]  idx_nxt;
    logic        last_entry;
    logic        is_self;

    assign n_clamped  = (neighbor_count > 16'd16) ? 5'd16 : neighbor_count[4:0];
    assign idx_nxt    = idx + 5'd1;
    assign last_entry = (idx_nxt == n_lat);
    assign cstate     = {4'd0, state};

`ifdef SKIP_SELF_EN
    assign is_self = (cur_id == MY_NODE_ID);
`else
    logic unused_node_id;
    assign is_self        = 1'b0;
    assign unused_node_id = ^MY_NODE_ID;
`endif

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state          <= S_IDLE;
            idx            <= 5'd0;
            k_cnt          <= 5'd0;
            n_lat          <= 5'd0;
            cur_id         <= 16'd0;
            cur_q          <= 16'd0;
            cur_hop        <= 16'd0;
            address        <= 16'd0;
            data_out       <= 16'd0;
            wr_en          <= 1'b0;
            mybest         <= 16'd0;
            bestvalue      <= 16'hFFFF;
            besthop        <= NONE_ID;
            bestneighborID <= NONE_ID;
            better_count   <= 16'd0;
            done_scan      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_scan) begin
                        mybest <= my_qvalue;
                        n_lat  <= n_clamped;
                        idx    <= 5'd0;
                        k_cnt  <= 5'd0;
                        state  <= S_INIT;
                    end
                end
                S_INIT: begin
                    bestvalue      <= 16'hFFFF;
                    besthop        <= NONE_ID;
                    bestneighborID <= NONE_ID;
                    if (n_lat == 5'd0) begin
                        state <= S_WR_COUNT;
                    end else begin
                        address <= ID_BASE;
                        state   <= S_RD_ID;
                    end
                end
                S_RD_ID: begin
                    cur_id  <= data_in;
                    address <= Q_BASE + {10'd0, idx, 1'b0};
                    state   <= S_RD_Q;
                end
                S_RD_Q: begin
                    cur_q   <= data_in;
                    address <= HOP_BASE + {10'd0, idx, 1'b0};
                    state   <= S_RD_HOP;
                end
                S_RD_HOP: begin
                    cur_hop <= data_in;
                    state   <= S_EVAL;
                end
                S_EVAL: begin
                    if (!is_self && (cur_q < bestvalue)) begin
                        bestvalue      <= cur_q;
                        besthop        <= cur_hop;
                        bestneighborID <= cur_id;
                    end
                    // The list write is launched here so the strobe lines up with WR_LIST,
                    // leaving WR_LIST free to address the next entry.
                    if (!is_self && (cur_q < mybest)) begin
                        address  <= LIST_BASE + {10'd0, k_cnt, 1'b0};
                        data_out <= cur_id;
                        wr_en    <= 1'b1;
                        k_cnt    <= k_cnt + 5'd1;
                        state    <= S_WR_LIST;
                    end else if (last_entry) begin
                        state <= S_WR_COUNT;
                    end else begin
                        idx     <= idx_nxt;
                        address <= ID_BASE + {10'd0, idx_nxt, 1'b0};
                        state   <= S_RD_ID;
                    end
                end
                S_WR_LIST: begin
                    if (last_entry) begin
                        state <= S_WR_COUNT;
                    end else begin
                        idx     <= idx_nxt;
                        address <= ID_BASE + {10'd0, idx_nxt, 1'b0};
                        state   <= S_RD_ID;
                    end
                end
                S_WR_COUNT: begin
                    address      <= COUNT_ADDR;
                    data_out     <= {11'd0, k_cnt};
                    wr_en        <= 1'b1;
                    better_count <= {11'd0, k_cnt};
                    state        <= S_DONE;
                end
                S_DONE: begin
                    if (done_scan && !start_scan) begin
                        done_scan <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        done_scan <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_best_neighbor_scan.sv
// Scoreboard bench for best_neighbor_scan: a behavioural table model predicts memory writes and results.
module tb_best_neighbor_scan;
    logic        clock = 1'b0;
    logic        nreset;
    logic        start_scan;
    logic [15:0] neighbor_count;
    logic [15:0] my_qvalue;
    logic [15:0] MY_NODE_ID;
    logic [15:0] data_in;
    logic [15:0] address;
    logic [15:0] data_out;
    logic        wr_en;
    logic [15:0] mybest;
    logic [15:0] bestvalue;
    logic [15:0] besthop;
    logic [15:0] bestneighborID;
    logic [15:0] better_count;
    logic        done_scan;
    logic [7:0]  cstate;

`ifdef SKIP_SELF_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] mem [0:4095];
    logic [15:0] tb_id  [0:15];
    logic [15:0] tb_q   [0:15];
    logic [15:0] tb_hop [0:15];
    logic [15:0] exp_bv, exp_bh, exp_bid, exp_cnt;
    int          exp_edges;
    int          n_tests = 0;
    int          n_fail  = 0;

    assign data_in = mem[address[11:0]];

    best_neighbor_scan dut (
        .clock(clock), .nreset(nreset), .start_scan(start_scan),
        .neighbor_count(neighbor_count), .my_qvalue(my_qvalue),
        .MY_NODE_ID(MY_NODE_ID), .data_in(data_in), .address(address),
        .data_out(data_out), .wr_en(wr_en), .mybest(mybest),
        .bestvalue(bestvalue), .besthop(besthop),
        .bestneighborID(bestneighborID), .better_count(better_count),
        .done_scan(done_scan), .cstate(cstate)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest predicted write.
    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            mem[address[11:0]] = data_out;
            if (exp_q.size() == 0) begin
                check_val("unexpected_wr_addr", {16'd0, address}, 32'hFFFFFFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check_val("wr_addr", {16'd0, address}, {16'd0, w.a});
                check_val("wr_data", {16'd0, data_out}, {16'd0, w.d});
            end
        end
    end

    task automatic model_scan(input int n, input logic [15:0] myq);
        int  nc;
        int  k;
        bit  self;
        wr_t w;
        nc = (n > 16) ? 16 : n;
        exp_bv = 16'hFFFF; exp_bh = 16'd100; exp_bid = 16'd100;
        k = 0;
        exp_edges = 4;
        for (int i = 0; i < nc; i++) begin
            self = SKIP && (tb_id[i] == MY_NODE_ID);
            exp_edges += 4;
            if (!self) begin
                if (tb_q[i] < exp_bv) begin
                    exp_bv = tb_q[i]; exp_bh = tb_hop[i]; exp_bid = tb_id[i];
                end
                if (tb_q[i] < myq) begin
                    w.a = 16'h0668 + 16'(2 * k);
                    w.d = tb_id[i];
                    exp_q.push_back(w);
                    k++;
                    exp_edges += 1;
                end
            end
        end
        w.a = 16'h068C;
        w.d = 16'(k);
        exp_q.push_back(w);
        exp_cnt = 16'(k);
    endtask

    task automatic load_table(input int n, input logic [15:0] myq);
        int nc;
        nc = (n > 16) ? 16 : n;
        for (int i = 0; i < nc; i++) begin
            mem[12'h600 + 12'(2 * i)] = tb_id[i];
            mem[12'h620 + 12'(2 * i)] = tb_q[i];
            mem[12'h640 + 12'(2 * i)] = tb_hop[i];
        end
        neighbor_count = 16'(n);
        my_qvalue      = myq;
        model_scan(n, myq);
    endtask

    task automatic run_scan(input string name, input int n, input logic [15:0] myq);
        int edges;
        load_table(n, myq);
        @(negedge clock);
        start_scan = 1'b1;
        edges = 0;
        while (edges < 300) begin
            @(posedge clock);
            #1;
            edges++;
            if (done_scan) break;
        end
        if (!done_scan) check_val({name, "_timeout"}, 32'd0, 32'd1);
        check_val({name, "_edges"}, 32'(edges), 32'(exp_edges));
        check_val({name, "_state"}, {24'd0, cstate}, 32'd8);
        check_val({name, "_bestvalue"}, {16'd0, bestvalue}, {16'd0, exp_bv});
        check_val({name, "_besthop"}, {16'd0, besthop}, {16'd0, exp_bh});
        check_val({name, "_bestid"}, {16'd0, bestneighborID}, {16'd0, exp_bid});
        check_val({name, "_count"}, {16'd0, better_count}, {16'd0, exp_cnt});
        check_val({name, "_mybest"}, {16'd0, mybest}, {16'd0, myq});
        @(negedge clock);
        check_val({name, "_pending_wr"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        start_scan = 1'b0;
        @(posedge clock);
        #1;
        check_val({name, "_release"}, {31'd0, done_scan}, 32'd0);
        check_val({name, "_idle"}, {24'd0, cstate}, 32'd0);
        @(negedge clock);
    endtask

    task automatic set_entry(input int i, input logic [15:0] id, input logic [15:0] q, input logic [15:0] hop);
        tb_id[i] = id; tb_q[i] = q; tb_hop[i] = hop;
    endtask

    task automatic set_basic3();
        set_entry(0, 16'd5, 16'h0040, 16'd1);
        set_entry(1, 16'd7, 16'h0020, 16'd2);
        set_entry(2, 16'd9, 16'h0080, 16'd3);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 16'd0;
        nreset = 1'b0; start_scan = 1'b0; neighbor_count = 16'd0;
        my_qvalue = 16'd0; MY_NODE_ID = 16'd3;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_val("rst_state", {24'd0, cstate}, 32'd0);
        check_val("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check_val("rst_done", {31'd0, done_scan}, 32'd0);
        check_val("rst_address", {16'd0, address}, 32'd0);
        check_val("rst_bestvalue", {16'd0, bestvalue}, 32'h0000FFFF);
        check_val("rst_besthop", {16'd0, besthop}, 32'd100);
        check_val("rst_bestid", {16'd0, bestneighborID}, 32'd100);
        check_val("rst_count", {16'd0, better_count}, 32'd0);
        check_val("rst_mybest", {16'd0, mybest}, 32'd0);
        nreset = 1'b1;
        @(negedge clock);

        set_basic3();
        run_scan("basic3", 3, 16'h0050);

        run_scan("empty", 0, 16'h0050);

        set_entry(0, 16'd11, 16'h0030, 16'd4);
        set_entry(1, 16'd12, 16'h0030, 16'd6);
        run_scan("tie", 2, 16'h0020);

        for (int i = 0; i < 16; i++) set_entry(i, 16'(20 + i), 16'h0001, 16'(i + 1));
        run_scan("clamp20", 20, 16'h0010);

        set_entry(0, 16'd3, 16'h0001, 16'd1);
        set_entry(1, 16'd8, 16'h0040, 16'd2);
        run_scan("self", 2, 16'h0050);

        set_entry(0, 16'd4, 16'hFFFF, 16'd9);
        run_scan("qmax", 1, 16'hFFFF);

        for (int r = 0; r < 2; r++) begin
            int n;
            n = $urandom_range(1, 18);
            for (int i = 0; i < 16; i++)
                set_entry(i, 16'($urandom_range(0, 40)), 16'($urandom_range(0, 128)), 16'($urandom_range(1, 10)));
            run_scan("random", n, 16'h0040);
        end

        // Reset while reading entry 1's Q-value, then scan again from scratch.
        set_basic3();
        load_table(3, 16'h0050);
        @(negedge clock);
        start_scan = 1'b1;
        repeat (8) begin
            @(posedge clock);
            #1;
        end
        check_val("midrst_pre_state", {24'd0, cstate}, 32'd3);
        nreset = 1'b0;
        @(posedge clock);
        #1;
        check_val("midrst_state", {24'd0, cstate}, 32'd0);
        check_val("midrst_wr_en", {31'd0, wr_en}, 32'd0);
        check_val("midrst_done", {31'd0, done_scan}, 32'd0);
        check_val("midrst_address", {16'd0, address}, 32'd0);
        check_val("midrst_data_out", {16'd0, data_out}, 32'd0);
        exp_q.delete();
        start_scan = 1'b0;
        @(negedge clock);
        nreset = 1'b1;
        @(negedge clock);
        run_scan("restart", 3, 16'h0050);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/best_neighbor_scan.md
BEST_NEIGHBOR_SCAN -- requirements
Module: best_neighbor_scan

Interface
REQ-001 SHALL have: clock  in  1  system clock (all logic on posedge); reset nreset, synchronous, active-low; clock clock.
REQ-002 SHALL have: nreset  in  1  synchronous active-low reset.
REQ-003 SHALL have: start_scan  in  1  level request to scan the neighbour table.
REQ-004 SHALL have: neighbor_count  in  16  table entries; values above 16 are clamped to 16.
REQ-005 SHALL have: my_qvalue  in  16  own Q-value, unsigned 12.4; lower is better.
REQ-006 SHALL have: MY_NODE_ID  in  16  own node ID.
REQ-007 SHALL have: data_in  in  16  memory read word; async read of address.
REQ-008 SHALL have: address  out  16  registered memory word address.
REQ-009 SHALL have: data_out  out  16  memory write word.
REQ-010 SHALL have: wr_en  out  1  one-cycle write strobe.
REQ-011 SHALL have: mybest, bestvalue, besthop, bestneighborID, better_count  out  16 each  scan results.
REQ-012 SHALL have: done_scan  out  1  scan complete; cstate  out  8  current state.

Function
REQ-013 Table layout: entry i (0..N-1) has ID at 16'h600+2i, Q at 16'h620+2i, hop at 16'h640+2i; better list at 16'h668+2k; count at 16'h68C.
REQ-014 data_in SHALL be sampled exactly one clock after address is loaded.
REQ-015 States: 0 IDLE, 1 INIT, 2 RD_ID, 3 RD_Q, 4 RD_HOP, 5 EVAL, 6 WR_LIST, 7 WR_COUNT, 8 DONE.
REQ-016 IDLE: on start_scan=1 latch mybest<=my_qvalue, i<=0, k<=0, go INIT; else stay.
REQ-017 INIT: bestvalue<=16'hFFFF, besthop<=100, bestneighborID<=100 (100 encodes -1); if N=0 go WR_COUNT, else address<=ID(0), go RD_ID.
REQ-018 RD_ID: capture ID, address<=Q(i); RD_Q: capture Q, address<=hop(i); RD_HOP: capture hop; go EVAL.
REQ-019 EVAL: if Q<bestvalue (strict) update bestvalue/besthop/bestneighborID; ties keep the lowest index.
REQ-020 EVAL: if Q<mybest (strict) go WR_LIST, else advance.
REQ-021 WR_LIST: address<=16'h668+2k, data_out<=ID, wr_en=1 for one cycle, k<=k+1; then advance.
REQ-022 Advance: if i=N-1 go WR_COUNT, else i<=i+1, address<=ID(i+1), go RD_ID.
REQ-023 WR_COUNT: address<=16'h68C, data_out<=k, wr_en=1 one cycle, better_count<=k; go DONE.
REQ-024 DONE: done_scan=1, results held; when start_scan=0, go IDLE with done_scan<=0.
REQ-025 start_scan changes outside IDLE/DONE SHALL be ignored.
REQ-026 Comparisons unsigned 16-bit; Q=16'hFFFF never beats initial bestvalue; k never exceeds 16.
REQ-027 Per-entry latency 4 cycles (5 if better); N=0 reaches DONE 3 cycles after start.

Reset
REQ-028 nreset=0 SHALL force state 0 next edge, including mid-scan; wr_en=0, done_scan=0, address=0, data_out=0.
REQ-029 Reset values: mybest=0, bestvalue=16'hFFFF, besthop=100, bestneighborID=100, better_count=0; partial list writes are not undone.

Configuration
REQ-030 Macro SKIP_SELF_EN defined: in EVAL an entry with ID==MY_NODE_ID SHALL skip both best update and list write.
REQ-031 SKIP_SELF_EN undefined: all entries SHALL be evaluated identically regardless of ID.

Verification
REQ-032 N=3, IDs{5,7,9}, Q{0x0040,0x0020,0x0080}, hops{1,2,3}, my_qvalue=0x0050 -> bestvalue=0x0020, besthop=2, bestneighborID=7; writes 5@0x668, 7@0x66A, 2@0x68C; better_count=2.
REQ-033 N=0, start_scan=1 -> single write 0@0x68C, bestvalue=0xFFFF, besthop=100, done_scan on 4th edge.
REQ-034 N=2, Q{0x0030,0x0030}, hops{4,6} -> besthop=4 (tie keeps index 0).
REQ-035 N=20, all Q=0x0001, my_qvalue=0x0010 -> 16 list writes (last at 0x686), better_count=16.
REQ-036 SKIP_SELF_EN, N=2, IDs{MY_NODE_ID=3, 8}, Q{0x0001,0x0040}, my_qvalue=0x0050 -> bestneighborID=8, better_count=1; without macro bestneighborID=3, better_count=2.
REQ-037 nreset=0 during RD_Q of entry 1 -> next edge state=0, wr_en=0, done_scan=0; restart completes normally.
